dibit_packer: RTL

- Downstream stage of the 3-input/sel steering logic; consumes its 2-bit `out` result, one symbol per accepted cycle.
- Packs SYMS_PER_WORD consecutive 2-bit symbols into one word for the next consumer.
- Valid/ready on both sides, a single-entry output register, and a flush request that emits a partial, zero-padded word.

---
 rtl/dibit_packer.sv | 106 ++++++++++
 1 files changed

// File: rtl/dibit_packer.sv
// dibit_packer: packs consecutive 2-bit symbols into SYMS_PER_WORD-symbol words.
// The module has one output register. A flush closes a partial word and pads it with zeros.
// Ports:
//   clk, rst            - clock and asynchronous active-high reset
//   in_valid/in_ready   - symbol handshake; in_data is the 2-bit symbol
//   flush               - one-cycle request to close the current word
//   out_valid/out_ready - word handshake
//   out_data            - packed word; symbol k is at bits [2k+1:2k]
//   out_count           - number of valid symbols in out_data
//   out_last            - the word was closed by a flush
module dibit_packer #(
    parameter int unsigned SYMS_PER_WORD = 4,
    localparam int unsigned CW = $clog2(SYMS_PER_WORD + 1),
    localparam int unsigned W  = 2 * SYMS_PER_WORD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_data,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_count,
    output logic          out_last
);

    localparam logic [CW-1:0] FULL_CNT = CW'(SYMS_PER_WORD);

    logic [W-1:0]  r_acc;
    logic [CW-1:0] r_cnt;
    logic          r_fp;
    logic          r_out_valid;
    logic [W-1:0]  r_out_data;
    logic [CW-1:0] r_out_count;
    logic          r_out_last;

    logic          w_accept;
    logic          w_slot_free;
    logic [W-1:0]  w_acc_next;
    logic [CW-1:0] w_cnt_next;
    logic          w_load;
    logic          w_fp_next;

    // The accumulator can take a symbol unless it is full or a flush is still waiting to drain.
    assign in_ready    = !rst && !r_fp && (r_cnt != FULL_CNT);
    assign w_accept    = in_valid && in_ready;
    assign w_slot_free = !r_out_valid || out_ready;

    // Accumulator after this cycle's symbol. Symbol k lands at bit 2k.
    always_comb begin
        w_acc_next = r_acc;
        w_cnt_next = r_cnt;
        if (w_accept) begin
            w_acc_next = r_acc | (W'(in_data) << {r_cnt, 1'b0});
            w_cnt_next = r_cnt + CW'(1);
        end
    end

    // Move the word into the output register when it is full or flushed and the slot is free.
    // A pending flush with an empty accumulator just clears itself.
    always_comb begin
        w_load    = w_slot_free && (w_cnt_next != '0) &&
                    ((w_cnt_next == FULL_CNT) || r_fp);
        w_fp_next = r_fp || flush;
        if (w_load || (r_fp && (r_cnt == '0))) begin
            w_fp_next = 1'b0;
        end
    end

    // Accumulator and output register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_fp        <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_last  <= 1'b0;
        end else begin
            r_fp <= w_fp_next;
            if (w_load) begin
                r_acc       <= '0;
                r_cnt       <= '0;
                r_out_valid <= 1'b1;
                r_out_data  <= w_acc_next;
                r_out_count <= w_cnt_next;
                r_out_last  <= r_fp || flush;
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
                if (out_ready) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_count = r_out_count;
    assign out_last  = r_out_last;

endmodule
